// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package riscv_loader_pkg;
  localparam int LEN_W  = 16;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
  } ld_state_e;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  function automatic logic takes_bytes(ld_state_e s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
  endfunction
endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instr_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (input in_valid, in_data,
                  output in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (output in_valid, in_data,
                  input in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/instr_loader_byte_packer.sv
// Little-endian byte-to-word packer; word_vld_o pulses combinationally with the 4th byte.
module byte_packer
  import riscv_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              byte_vld_i,
  input  logic [7:0]        byte_i,
  output logic              word_vld_o,
  output logic [WORD_W-1:0] word_o
);
  logic [23:0] shreg_q;
  logic [1:0]  cnt_q;

  // Bytes enter at the top, so the first byte ends up in bits 7:0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (clr_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (byte_vld_i) begin
      shreg_q <= {byte_i, shreg_q[23:8]};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  assign word_vld_o = byte_vld_i && (cnt_q == 2'd3);
  assign word_o     = {byte_i, shreg_q};
endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory,
// holding the core in reset until the whole image has been written.
module instr_loader
  import riscv_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  instr_loader_if.master bus,
  output logic           core_rst,
  output logic           busy,
  output logic           done,
  output logic           err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;

  ld_state_e        state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [IDX_W-1:0] idx_q;
  logic             in_ready_q, busy_q, done_q, err_q, core_rst_q;
  mem_req_t         mem_q;

  logic              xfer, restart, pk_vld;
  logic [WORD_W-1:0] pk_word;
  logic [LEN_W-1:0]  len_full, idx_next;

  assign xfer     = bus.in_valid && in_ready_q;
  assign restart  = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign len_full = {bus.in_data, len_q[7:0]};
  assign idx_next = LEN_W'(idx_q) + LEN_W'(1);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (restart),
    .byte_vld_i (xfer && state_q == DATA),
    .byte_i     (bus.in_data),
    .word_vld_o (pk_vld),
    .word_o     (pk_word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LEN_LO;
      LEN_LO:          if (xfer) state_d = LEN_HI;
      LEN_HI: if (xfer) begin
        if (len_full == '0)                         state_d = DONE;
        else if (len_full > LEN_W'(DEPTH_WORDS))    state_d = ERR;
        else                                        state_d = DATA;
      end
      DATA:            if (pk_vld) state_d = WRITE;
      WRITE:           state_d = (idx_next == len_q) ? DONE : DATA;
      default:         state_d = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
      mem_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= takes_bytes(state_d);
      busy_q     <= takes_bytes(state_d) || (state_d == WRITE);
      done_q     <= (state_d == DONE);
      err_q      <= (state_d == ERR);
      core_rst_q <= (state_d != DONE);
      mem_q.we   <= (state_d == WRITE);
      if (restart) begin
        len_q <= '0;
        idx_q <= '0;
      end
      if (state_q == LEN_LO && xfer) len_q[7:0] <= bus.in_data;
      if (state_q == LEN_HI && xfer) len_q      <= len_full;
      if (state_q == DATA && pk_vld) begin
        mem_q.addr  <= WORD_W'({idx_q, 2'b00});
        mem_q.wdata <= pk_word;
      end
      // Index stops at N-1 so it never leaves the memory range.
      if (state_q == WRITE && idx_next != len_q) idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_q.we;
  assign bus.mem_addr  = mem_q.addr;
  assign bus.mem_wdata = mem_q.wdata;
  assign core_rst      = core_rst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
endmodule

// File: tb/tb_instr_loader.sv
// Table, directed and randomized checks of instr_loader against a stream-level model.
module tb_instr_loader;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic core_rst, busy, done, err;

  instr_loader_if bus();

  instr_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int n; bit exp_done; bit exp_err; int exp_writes; } vec_t;

  int  checks = 0;
  int  errors = 0;
  wr_t wr_q[$];
  wr_t exp_q[$];

  always @(negedge clk)
    if (rst && bus.mem_we) wr_q.push_back('{bus.mem_addr, bus.mem_wdata});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    bit acc;
    int n;
    while ($urandom_range(99) < stall) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      acc = bus.in_ready;
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("byte_accept_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || err) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("session_end", done || err, 1);
  endtask

  task automatic run_session(input bq_t bs, input int stall);
    wr_q.delete();
    pulse_start();
    foreach (bs[i]) send_byte(bs[i], stall);
    wait_end();
    repeat (2) @(negedge clk);
  endtask

  // Reference: header gives N; N>DEPTH is an error, otherwise word i is bytes
  // 2+4i..5+4i little-endian written at byte address 4i.
  task automatic model(input bq_t bs, output bit exp_err);
    int n;
    n = int'(bs[0]) + (int'(bs[1]) * 256);
    exp_q.delete();
    exp_err = (n > DEPTH);
    if (!exp_err)
      for (int i = 0; i < n; i++)
        exp_q.push_back('{32'(4 * i),
          {bs[2+4*i+3], bs[2+4*i+2], bs[2+4*i+1], bs[2+4*i]}});
  endtask

  task automatic mk(input int n, output bq_t bs);
    logic [15:0] n16;
    n16 = 16'(n);
    bs.delete();
    bs.push_back(n16[7:0]);
    bs.push_back(n16[15:8]);
    if (n <= DEPTH)
      for (int i = 0; i < 4 * n; i++) bs.push_back(8'($urandom));
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk({tag, "_addr"}, wr_q[i].addr, exp_q[i].addr);
      chk({tag, "_data"}, wr_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic check_status(input string tag, input bit exp_err);
    chk({tag, "_done"}, done, !exp_err);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_core_rst"}, core_rst, exp_err);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_core_rst"}, core_rst, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    vec_t tbl[$];
    bq_t  bs;
    bit   e;
    int   n;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    // Length boundaries
    tbl.push_back('{0,      1, 0, 0});
    tbl.push_back('{1,      1, 0, 1});
    tbl.push_back('{3,      1, 0, 3});
    tbl.push_back('{64,     1, 0, 64});
    tbl.push_back('{65,     0, 1, 0});
    tbl.push_back('{256,    0, 1, 0});
    tbl.push_back('{65535,  0, 1, 0});
    for (int i = 0; i < tbl.size(); i++) begin
      mk(tbl[i].n, bs);
      run_session(bs, (i % 2) * 30);
      model(bs, e);
      chk("tbl_done", done, tbl[i].exp_done);
      chk("tbl_err", err, tbl[i].exp_err);
      chk("tbl_writes", wr_q.size(), tbl[i].exp_writes);
      check_writes("tbl");
    end

    // Two-word image with exact write timing
    wr_q.delete();
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h33, 0); send_byte(8'hd2, 0); send_byte(8'h62, 0);
    send_byte(8'h40, 0);
    chk("w0_we", bus.mem_we, 1);
    chk("w0_addr", bus.mem_addr, 32'h0);
    chk("w0_data", bus.mem_wdata, 32'h4062d233);
    chk("w0_core_rst", core_rst, 1);
    @(negedge clk);
    chk("w0_we_one_cycle", bus.mem_we, 0);
    chk("w0_addr_hold", bus.mem_addr, 32'h0);
    send_byte(8'h33, 0); send_byte(8'hd2, 0); send_byte(8'h83, 0);
    send_byte(8'h40, 0);
    chk("w1_we", bus.mem_we, 1);
    chk("w1_addr", bus.mem_addr, 32'h4);
    chk("w1_data", bus.mem_wdata, 32'h4083d233);
    chk("w1_core_rst", core_rst, 1);
    @(negedge clk);
    chk("w1_core_rst_fall", core_rst, 0);
    chk("w1_done", done, 1);
    chk("w1_wdata_hold", bus.mem_wdata, 32'h4083d233);
    chk("w1_nwrites", wr_q.size(), 2);

    // Zero-length image
    wr_q.delete();
    pulse_start();
    send_byte(8'h00, 0);
    chk("zero_core_rst_hi", core_rst, 1);
    send_byte(8'h00, 0);
    chk("zero_core_rst_lo", core_rst, 0);
    chk("zero_done", done, 1);
    repeat (3) @(negedge clk);
    chk("zero_nwrites", wr_q.size(), 0);

    // Oversized length
    bs = '{8'h41, 8'h00};
    run_session(bs, 0);
    repeat (5) @(negedge clk);
    check_status("over", 1);
    chk("over_nwrites", wr_q.size(), 0);

    // start while loading must be ignored
    wr_q.delete();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    pulse_start();
    send_byte(8'h33, 0); send_byte(8'h44, 0);
    wait_end();
    repeat (2) @(negedge clk);
    chk("ign_nwrites", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("ign_data", wr_q[0].data, 32'h44332211);
    chk("ign_done", done, 1);

    // Stalled single word
    for (int k = 0; k < 3; k++) begin
      bs = '{8'h01, 8'h00, 8'hef, 8'hbe, 8'had, 8'hde};
      run_session(bs, 60);
      model(bs, e);
      check_writes("stall");
      check_status("stall", e);
    end

    // Reset mid-session, then a clean one-word load
    wr_q.delete();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'haa, 0); send_byte(8'hbb, 0);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_nwrites", wr_q.size(), 0);
    bs = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    run_session(bs, 0);
    chk("after_abort_nwrites", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      chk("after_abort_addr", wr_q[0].addr, 32'h0);
      chk("after_abort_data", wr_q[0].data, 32'h00000013);
    end

    // Randomized sessions
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(4))
        0:       n = $urandom_range(1000, 65);
        1:       n = DEPTH;
        default: n = $urandom_range(6);
      endcase
      mk(n, bs);
      run_session(bs, $urandom_range(50));
      model(bs, e);
      check_writes("rand");
      check_status("rand", e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
